epl_accumulator: RTL and testbench
==================================

EPL_ACCUMULATOR -- requirements
Module: epl_accumulator

Interface
REQ-001 Parameter: ACC_W, 16, width of each accumulator and dump register (two's complement).
REQ-002 Port: clk  input  1  single clock; all logic on posedge.
REQ-003 Port: rstn  input  1  reset, synchronous, active-low.
REQ-004 Port: sample_enable  input  1  one-cycle strobe marking a valid baseband sample.
REQ-005 Port: i_bb  input  3  signed in-phase baseband sample, range -4..+3.
REQ-006 Port: q_bb  input  3  signed quadrature baseband sample, range -4..+3.
REQ-007 Port: early, prompt, late  input  1 each  half-chip spaced C/A chips from the code generator.
REQ-008 Port: dump_enable  input  1  one-cycle pulse marking the C/A code period boundary.
REQ-009 Port: read_ack  input  1  one-cycle pulse from the bus side; clears dump_flag and overrun.
REQ-010 Port: i_early, q_early, i_prompt, q_prompt, i_late, q_late  output  ACC_W each  dumped sums, registered.
REQ-011 Port: dump_flag  output  1  new dumped sums available.
REQ-012 Port: overrun  output  1  sticky; a dump occurred before the previous one was acknowledged.

Function
REQ-013 Chip mapping SHALL be: chip 0 -> multiply by +1; chip 1 -> multiply by -1 (negate the sample).
REQ-014 Six running accumulators (I/Q x E/P/L) SHALL add the chip-multiplied sample, sign-extended to ACC_W, only on cycles with sample_enable=1.
REQ-015 A sample SHALL be visible in the accumulator on the cycle after its sample_enable.
REQ-016 On dump_enable=1, the six output registers SHALL load the current accumulator values on the next clock edge.
REQ-017 If sample_enable and dump_enable coincide, that sample SHALL be excluded from the dumped values and SHALL become the first term of the new period (accumulator <- contribution).
REQ-018 Without a coincident sample, a dump SHALL clear all accumulators to 0.
REQ-019 Output registers SHALL hold their value between dumps, independent of read_ack.
REQ-020 dump_flag SHALL be set on the cycle after dump_enable and cleared on the cycle after read_ack; if both occur together, set wins.
REQ-021 overrun SHALL be set when dump_enable occurs while dump_flag=1 and read_ack=0; it SHALL be cleared only by read_ack or reset.
REQ-022 Arithmetic overflow behaviour SHALL follow REQ-026/REQ-027.

Reset
REQ-023 With rstn=0 at a clock edge, all accumulators, output registers, dump_flag and overrun SHALL be 0 on the following cycle.
REQ-024 Reset SHALL override sample_enable, dump_enable and read_ack in the same cycle; the partial period in progress is discarded.
REQ-025 The first dump after reset SHALL report only the samples accepted after reset.

Configuration
REQ-026 Macro ACCUM_SATURATE_EN defined: each accumulator SHALL clamp at +(2^(ACC_W-1)-1) and -2^(ACC_W-1) instead of overflowing.
REQ-027 Macro ACCUM_SATURATE_EN undefined: accumulators SHALL wrap modulo 2^ACC_W; no clamp logic is present.

Verification
REQ-028 Reset, then 10 samples i_bb=+3, q_bb=-2, early=prompt=late=0, then dump -> i_*=30, q_*=-20, dump_flag=1, overrun=0.
REQ-029 5 samples i_bb=+1, prompt=1, early=late=0, then dump -> i_prompt=-5, i_early=+5, i_late=+5.
REQ-030 sample i_bb=+2 coincident with dump after 4 samples of +1 -> i_early=4; next dump with no further samples -> i_early=2.
REQ-031 Two dumps with no read_ack between -> overrun=1, dump_flag=1; read_ack -> both 0 next cycle; read_ack coincident with a third dump -> dump_flag=1, overrun=0.
REQ-032 ACC_W=8, 50 samples i_bb=+3 -> with ACCUM_SATURATE_EN i_early=127; without it i_early=150-256=-106.
REQ-033 rstn=0 mid-period after 7 samples, then 3 samples of +1 and dump -> i_early=3.

Source files
------------

// File: rtl/epl_accumulator.sv
// Early/prompt/late correlator: six I/Q integrate-and-dump accumulators with registered dump outputs.
// Define ACCUM_SATURATE_EN to clamp accumulators instead of wrapping modulo 2^ACC_W.
module epl_accumulator #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sample_enable,
  input  logic [2:0]       i_bb,
  input  logic [2:0]       q_bb,
  input  logic             early,
  input  logic             prompt,
  input  logic             late,
  input  logic             dump_enable,
  input  logic             read_ack,
  output logic [ACC_W-1:0] i_early,
  output logic [ACC_W-1:0] q_early,
  output logic [ACC_W-1:0] i_prompt,
  output logic [ACC_W-1:0] q_prompt,
  output logic [ACC_W-1:0] i_late,
  output logic [ACC_W-1:0] q_late,
  output logic             dump_flag,
  output logic             overrun
);

  localparam int NCH = 6;

  logic [ACC_W-1:0]          i_ext;
  logic [ACC_W-1:0]          q_ext;
  logic [2:0]                chip;
  logic [NCH-1:0][ACC_W-1:0] dump_vec;

  assign i_ext = {{(ACC_W-3){i_bb[2]}}, i_bb};
  assign q_ext = {{(ACC_W-3){q_bb[2]}}, q_bb};
  assign chip  = {late, prompt, early};

  // Channel order: 0..2 = I early/prompt/late, 3..5 = Q early/prompt/late.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      localparam int TAP = gi % 3;

      logic [ACC_W-1:0] sample;
      logic [ACC_W-1:0] contrib;
      logic [ACC_W-1:0] add_val;
      logic [ACC_W-1:0] acc_q;
      logic [ACC_W-1:0] acc_d;
      logic [ACC_W-1:0] dump_q;
      logic [ACC_W-1:0] dump_d;
`ifdef ACCUM_SATURATE_EN
      logic [ACC_W:0]   sum;
`else
      logic [ACC_W-1:0] sum;
`endif

      assign sample = (gi >= 3) ? q_ext : i_ext;

      always_comb begin
        contrib = chip[TAP] ? (ACC_W'(0) - sample) : sample;
`ifdef ACCUM_SATURATE_EN
        // One extra bit exposes signed overflow: top two bits disagree.
        sum = {acc_q[ACC_W-1], acc_q} + {contrib[ACC_W-1], contrib};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          add_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          add_val = sum[ACC_W-1:0];
        end
`else
        sum     = acc_q + contrib;
        add_val = sum;
`endif
        acc_d  = acc_q;
        dump_d = dump_q;
        if (dump_enable) begin
          // A coincident sample opens the next period rather than closing this one.
          dump_d = acc_q;
          acc_d  = sample_enable ? contrib : '0;
        end else if (sample_enable) begin
          acc_d = add_val;
        end
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          acc_q  <= '0;
          dump_q <= '0;
        end else begin
          acc_q  <= acc_d;
          dump_q <= dump_d;
        end
      end

      assign dump_vec[gi] = dump_q;
    end
  endgenerate

  assign i_early  = dump_vec[0];
  assign i_prompt = dump_vec[1];
  assign i_late   = dump_vec[2];
  assign q_early  = dump_vec[3];
  assign q_prompt = dump_vec[4];
  assign q_late   = dump_vec[5];

  logic dump_flag_q;
  logic dump_flag_d;
  logic overrun_q;
  logic overrun_d;

  always_comb begin
    dump_flag_d = dump_flag_q;
    overrun_d   = overrun_q;
    if (read_ack) begin
      dump_flag_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (dump_enable) begin
      dump_flag_d = 1'b1;
      if (dump_flag_q && !read_ack) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dump_flag_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dump_flag_q <= dump_flag_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dump_flag = dump_flag_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_epl_accumulator.sv
// Self-checking bench: a 16-bit and an 8-bit accumulator driven in parallel against an integer model.
module tb_epl_accumulator;

  localparam int WA = 16;
  localparam int WB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, sample_enable, early, prompt, late, dump_enable, read_ack;
  logic [2:0] i_bb, q_bb;

  logic [WA-1:0] a_ie, a_qe, a_ip, a_qp, a_il, a_ql;
  logic          a_flag, a_ovr;
  logic [WB-1:0] b_ie, b_qe, b_ip, b_qp, b_il, b_ql;
  logic          b_flag, b_ovr;

  epl_accumulator #(.ACC_W(WA)) dut_a (
    .clk(clk), .rstn(rstn), .sample_enable(sample_enable), .i_bb(i_bb), .q_bb(q_bb),
    .early(early), .prompt(prompt), .late(late), .dump_enable(dump_enable), .read_ack(read_ack),
    .i_early(a_ie), .q_early(a_qe), .i_prompt(a_ip), .q_prompt(a_qp), .i_late(a_il), .q_late(a_ql),
    .dump_flag(a_flag), .overrun(a_ovr)
  );

  epl_accumulator #(.ACC_W(WB)) dut_b (
    .clk(clk), .rstn(rstn), .sample_enable(sample_enable), .i_bb(i_bb), .q_bb(q_bb),
    .early(early), .prompt(prompt), .late(late), .dump_enable(dump_enable), .read_ack(read_ack),
    .i_early(b_ie), .q_early(b_qe), .i_prompt(b_ip), .q_prompt(b_qp), .i_late(b_il), .q_late(b_ql),
    .dump_flag(b_flag), .overrun(b_ovr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain integers, one entry per width, channel order IE IP IL QE QP QL.
  int    macc [2][6];
  int    mout [2][6];
  bit    mflag, movr;
  int    widths [2] = '{WA, WB};
  string nm [6] = '{"i_early", "i_prompt", "i_late", "q_early", "q_prompt", "q_late"};

  function automatic int norm(input int x, input int w);
    int lo, hi, m;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
`ifdef ACCUM_SATURATE_EN
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
`else
    m = x & ((1 << w) - 1);
    if (m > hi) m = m - (1 << w);
    return m;
`endif
  endfunction

  task automatic model_step(input bit rst, input bit sev, input int iv, input int qv,
                            input bit ev, input bit pv, input bit lv, input bit dv, input bit av);
    bit chips [3];
    int s, c;
    bit prev_flag;
    chips = '{ev, pv, lv};
    if (rst) begin
      foreach (macc[w, ch]) begin
        macc[w][ch] = 0;
        mout[w][ch] = 0;
      end
      mflag = 0;
      movr  = 0;
      return;
    end
    for (int w = 0; w < 2; w++) begin
      for (int ch = 0; ch < 6; ch++) begin
        s = (ch < 3) ? iv : qv;
        c = chips[ch % 3] ? -s : s;
        if (dv) begin
          mout[w][ch] = macc[w][ch];
          macc[w][ch] = sev ? norm(c, widths[w]) : 0;
        end else if (sev) begin
          macc[w][ch] = norm(macc[w][ch] + c, widths[w]);
        end
      end
    end
    prev_flag = mflag;
    if (dv) mflag = 1;
    else if (av) mflag = 0;
    if (dv && prev_flag && !av) movr = 1;
    else if (av) movr = 0;
  endtask

  task automatic compare_all();
    int obs [2][6];
    obs[0] = '{int'($signed(a_ie)), int'($signed(a_ip)), int'($signed(a_il)),
               int'($signed(a_qe)), int'($signed(a_qp)), int'($signed(a_ql))};
    obs[1] = '{int'($signed(b_ie)), int'($signed(b_ip)), int'($signed(b_il)),
               int'($signed(b_qe)), int'($signed(b_qp)), int'($signed(b_ql))};
    for (int w = 0; w < 2; w++)
      for (int ch = 0; ch < 6; ch++)
        chk($sformatf("w%0d_%s", widths[w], nm[ch]), obs[w][ch], mout[w][ch]);
    chk("a_dump_flag", int'(a_flag), int'(mflag));
    chk("a_overrun",   int'(a_ovr),  int'(movr));
    chk("b_dump_flag", int'(b_flag), int'(mflag));
    chk("b_overrun",   int'(b_ovr),  int'(movr));
  endtask

  task automatic cyc(input bit rst, input bit sev, input int iv, input int qv,
                     input bit ev, input bit pv, input bit lv, input bit dv, input bit av);
    rstn          = !rst;
    sample_enable = sev;
    i_bb          = 3'(iv);
    q_bb          = 3'(qv);
    early         = ev;
    prompt        = pv;
    late          = lv;
    dump_enable   = dv;
    read_ack      = av;
    @(posedge clk);
    model_step(rst, sev, iv, qv, ev, pv, lv, dv, av);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ack();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic dump(input bit sev, input int iv);
    cyc(0, sev, iv, 0, 0, 0, 0, 1, 0);
  endtask

  int  iv, qv;
  bit  sev, dv, av, rst;

  initial begin
    rstn = 1'b0; sample_enable = 0; i_bb = '0; q_bb = '0;
    early = 0; prompt = 0; late = 0; dump_enable = 0; read_ack = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 3, 0, 0, 0, 1, 1);
    chk("reset_flag", int'(a_flag), 0);
    chk("reset_ie", int'($signed(a_ie)), 0);

    // 10 samples (+3, -2), all chips 0
    for (int k = 0; k < 10; k++) cyc(0, 1, 3, -2, 0, 0, 0, 0, 0);
    dump(0, 0);
    chk("r28_i_early", int'($signed(a_ie)), 30);
    chk("r28_q_late",  int'($signed(a_ql)), -20);
    chk("r28_flag",    int'(a_flag), 1);
    chk("r28_overrun", int'(a_ovr), 0);
    ack();

    // prompt chip 1 negates
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0, 0, 1, 0, 0, 0);
    dump(0, 0);
    chk("r29_i_prompt", int'($signed(a_ip)), -5);
    chk("r29_i_early",  int'($signed(a_ie)), 5);
    chk("r29_i_late",   int'($signed(a_il)), 5);
    ack();

    // coincident sample starts the next period
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    dump(1, 2);
    chk("r30_first", int'($signed(a_ie)), 4);
    idle();
    dump(0, 0);
    chk("r30_second", int'($signed(a_ie)), 2);
    chk("r30_overrun", int'(a_ovr), 1);

    ack();
    chk("r31_ack_flag", int'(a_flag), 0);
    dump(0, 0);
    dump(0, 0);
    chk("r31_ovr_set",  int'(a_ovr), 1);
    chk("r31_flag_set", int'(a_flag), 1);
    ack();
    chk("r31_ack_ovr",  int'(a_ovr), 0);
    chk("r31_ack_flag2", int'(a_flag), 0);
    dump(0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("r31_both_flag", int'(a_flag), 1);
    chk("r31_both_ovr",  int'(a_ovr), 0);

    // 50 x +3 overflows the 8-bit instance
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 50; k++) cyc(0, 1, 3, 0, 0, 0, 0, 0, 0);
    dump(0, 0);
    chk("r32_w16", int'($signed(a_ie)), 150);
`ifdef ACCUM_SATURATE_EN
    chk("r32_w8", int'($signed(b_ie)), 127);
`else
    chk("r32_w8", int'($signed(b_ie)), -106);
`endif
    ack();

    // reset mid-period discards partial sums
    for (int k = 0; k < 7; k++) cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    dump(0, 0);
    chk("r33_i_early", int'($signed(a_ie)), 3);
    chk("r33_w8", int'($signed(b_ie)), 3);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      sev = ($urandom_range(0, 3) != 0);
      iv  = int'($urandom_range(0, 7)) - 4;
      qv  = int'($urandom_range(0, 7)) - 4;
      dv  = ($urandom_range(0, 19) == 0);
      av  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cyc(rst, sev, iv, qv, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), dv, av);
    end

    // long biased periods to exercise the 8-bit overflow path
    for (int k = 0; k < 1500; k++) begin
      iv = ($urandom_range(0, 4) == 0) ? -4 : 3;
      qv = ($urandom_range(0, 4) == 0) ? 3 : -4;
      dv = ($urandom_range(0, 99) == 0);
      av = ($urandom_range(0, 3) == 0);
      cyc(0, 1, iv, qv, 0, $urandom_range(0, 1), 1, dv, av);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
